// File: rtl/icache_fetch_resp.sv
// Direct-mapped instruction cache (4-word lines) returning the instruction pair at PC and PC+4.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_fetch_resp #(
   parameter int INDEX_WIDTH = 6
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] pc_IF1,
   input  logic        is_valid,
   input  logic        flush_BR,
   output logic [31:0] o_IR1,
   output logic [31:0] o_IR2,
   output logic [1:0]  o_valid,
   output logic        stall_ICache,
   output logic        mem_rreq,
   output logic [31:0] mem_raddr,
   input  logic        mem_rgrant,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rlast
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int LINES     = 1 << INDEX_WIDTH;
   localparam int TAG_WIDTH = 28 - INDEX_WIDTH;

   typedef enum logic [1:0] {
      LOOKUP,
      MISS_REQ,
      REFILL
   } state_t;

   state_t state, state_next;

   logic [31:2]            req_pc;
   logic                   req_v;
   logic                   cancel;
   logic [1:0]             beat_cnt;
   logic [LINES-1:0]       line_valid;
   logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
   logic [31:0]            data_mem [LINES*4];

   logic [INDEX_WIDTH-1:0] req_idx;
   logic [TAG_WIDTH-1:0]   req_tag;
   logic [1:0]             req_off;
   logic [1:0]             off_next;
   logic [1:0]             beat_sel;
   logic                   hit;
   logic                   lookup_hit;
   logic                   lookup_miss;
   logic                   miss_start;
   logic                   pc_lsb_unused;

   assign pc_lsb_unused = ^pc_IF1[1:0];

   assign req_idx  = req_pc[3+INDEX_WIDTH:4];
   assign req_tag  = req_pc[31:4+INDEX_WIDTH];
   assign req_off  = req_pc[3:2];
   assign off_next = req_off + 2'd1;
   assign beat_sel = mem_rlast ? 2'd3 : beat_cnt;

   assign hit         = line_valid[req_idx] && (tag_mem[req_idx] == req_tag);
   assign lookup_hit  = (state == LOOKUP) && req_v && hit;
   assign lookup_miss = (state == LOOKUP) && req_v && !hit;
   // A flush in the miss-detect cycle abandons the miss instead of starting a refill.
   assign miss_start  = lookup_miss && !flush_BR;

   always_comb begin
      state_next = state;
      mem_rreq   = 1'b0;
      mem_raddr  = 32'd0;
      case (state)
         LOOKUP: begin
            if (miss_start) state_next = MISS_REQ;
         end
         MISS_REQ: begin
            mem_rreq  = 1'b1;
            mem_raddr = {req_pc[31:4], 4'b0000};
            if (mem_rgrant) state_next = REFILL;
         end
         REFILL: begin
            if (mem_rvalid && mem_rlast) state_next = LOOKUP;
         end
         default: state_next = LOOKUP;
      endcase
   end

   always_comb begin
      o_valid      = {lookup_hit, lookup_hit && (req_off != 2'd3)};
      o_IR1        = o_valid[1] ? data_mem[{req_idx, req_off}] : 32'd0;
      o_IR2        = o_valid[0] ? data_mem[{req_idx, off_next}] : 32'd0;
      stall_ICache = (state != LOOKUP) || lookup_miss;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= LOOKUP;
         req_pc     <= '0;
         req_v      <= 1'b0;
         cancel     <= 1'b0;
         beat_cnt   <= 2'd0;
         line_valid <= '0;
      end else begin
         state <= state_next;
         case (state)
            LOOKUP: begin
               if (!miss_start) begin
                  req_v <= is_valid;
                  if (is_valid) req_pc <= pc_IF1[31:2];
               end
            end
            MISS_REQ: begin
               beat_cnt <= 2'd0;
               if (flush_BR) cancel <= 1'b1;
            end
            REFILL: begin
               if (flush_BR) cancel <= 1'b1;
               if (mem_rvalid) begin
                  beat_cnt <= beat_cnt + 2'd1;
                  // req_pc is kept so the following cycle re-looks-up and hits.
                  if (mem_rlast) begin
                     line_valid[req_idx] <= 1'b1;
                     req_v               <= !(cancel || flush_BR);
                     cancel              <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == REFILL && mem_rvalid) begin
         data_mem[{req_idx, beat_sel}] <= mem_rdata;
         if (mem_rlast) tag_mem[req_idx] <= req_tag;
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   logic relookup;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         relookup <= 1'b0;
         hit_cnt  <= 32'd0;
         miss_cnt <= 32'd0;
      end else begin
         relookup <= (state == REFILL) && mem_rvalid && mem_rlast && !cancel && !flush_BR;
         if (lookup_hit && !relookup)  hit_cnt  <= hit_cnt + 32'd1;
         if (lookup_miss && !relookup) miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_fetch_resp.sv
// Scoreboard bench for icache_fetch_resp with a behavioural backing memory that grants and streams lines.
module tb_icache_fetch_resp;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] pc_IF1;
   logic        is_valid;
   logic        flush_BR;
   logic [31:0] o_IR1;
   logic [31:0] o_IR2;
   logic [1:0]  o_valid;
   logic        stall_ICache;
   logic        mem_rreq;
   logic [31:0] mem_raddr;
   logic        mem_rgrant;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        mem_rlast;

   icache_fetch_resp #(.INDEX_WIDTH(6)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .pc_IF1       (pc_IF1),
      .is_valid     (is_valid),
      .flush_BR     (flush_BR),
      .o_IR1        (o_IR1),
      .o_IR2        (o_IR2),
      .o_valid      (o_valid),
      .stall_ICache (stall_ICache),
      .mem_rreq     (mem_rreq),
      .mem_raddr    (mem_raddr),
      .mem_rgrant   (mem_rgrant),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .mem_rlast    (mem_rlast)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] ir1;
      logic [31:0] ir2;
      logic [1:0]  v;
   } resp_t;

   resp_t       sb_q[$];
   int          errors = 0;
   int          checks = 0;
   int          req_count = 0;
   int          beats_sent = 0;
   int          grant_delay = 1;
   bit          mem_busy = 1'b0;
   logic [31:0] last_addr = 32'd0;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a[31:4] == 28'h1C00000) return 32'h11 * (32'(a[3:2]) + 32'd1);
      return a ^ 32'h5A5A_5A5A;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Backing memory: grants after grant_delay cycles, then streams four beats back to back.
   initial begin
      mem_rgrant = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
      mem_rlast  = 1'b0;
      forever begin
         @(negedge clk);
         if (rstn === 1'b1 && mem_rreq === 1'b1) begin
            mem_busy   = 1'b1;
            beats_sent = 0;
            req_count++;
            last_addr  = mem_raddr;
            repeat (grant_delay - 1) @(negedge clk);
            mem_rgrant = 1'b1;
            @(negedge clk);
            mem_rgrant = 1'b0;
            for (int k = 0; k < 4; k++) begin
               mem_rvalid = 1'b1;
               mem_rdata  = memWord(last_addr + 32'(4 * k));
               mem_rlast  = (k == 3);
               beats_sent = k + 1;
               @(negedge clk);
            end
            mem_rvalid = 1'b0;
            mem_rlast  = 1'b0;
            mem_rdata  = 32'd0;
            mem_busy   = 1'b0;
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] pc, input bit expect_resp);
      resp_t r;
      if (expect_resp) begin
         r.ir1 = memWord(pc);
         r.ir2 = (pc[3:2] == 2'd3) ? 32'd0 : memWord(pc + 32'd4);
         r.v   = (pc[3:2] == 2'd3) ? 2'b10 : 2'b11;
         sb_q.push_back(r);
      end
      pc_IF1   = pc;
      is_valid = 1'b1;
      @(negedge clk);
      is_valid = 1'b0;
   endtask

   task automatic waitResponse(input string tag, output int cycles, output int stall_low);
      resp_t e;
      cycles    = 0;
      stall_low = 0;
      while (o_valid == 2'b00 && cycles < 60) begin
         if (!stall_ICache) stall_low++;
         @(negedge clk);
         cycles++;
      end
      if (o_valid == 2'b00) begin
         checkOutput({tag, "_timeout"}, 32'(o_valid != 2'b00), 32'd1);
      end else if (sb_q.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         checkOutput({tag, "_ir1"}, o_IR1, e.ir1);
         checkOutput({tag, "_ir2"}, o_IR2, e.ir2);
         checkOutput({tag, "_valid"}, 32'(o_valid), 32'(e.v));
         checkOutput({tag, "_stall_hit"}, 32'(stall_ICache), 32'd0);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_valid"}, 32'(o_valid), 32'd0);
      checkOutput({tag, "_ir1"}, o_IR1, 32'd0);
      checkOutput({tag, "_ir2"}, o_IR2, 32'd0);
      checkOutput({tag, "_stall"}, 32'(stall_ICache), 32'd0);
      checkOutput({tag, "_rreq"}, 32'(mem_rreq), 32'd0);
      checkOutput({tag, "_raddr"}, mem_raddr, 32'd0);
   endtask

   initial begin
      int cyc, slow, r0, seen;
      rstn     = 1'b0;
      pc_IF1   = 32'd0;
      is_valid = 1'b0;
      flush_BR = 1'b0;
      repeat (2) @(negedge clk);
      checkResetOutputs("reset");
      rstn = 1'b1;
      @(negedge clk);

      // Cold miss with a two-cycle grant wait.
      grant_delay = 2;
      r0 = req_count;
      applyStimulus(32'h1C00_0000, 1'b1);
      waitResponse("cold", cyc, slow);
      checkOutput("cold_reqs", 32'(req_count - r0), 32'd1);
      checkOutput("cold_addr", last_addr, 32'h1C00_0000);
      checkOutput("cold_latency", 32'(cyc), 32'd7);
      checkOutput("cold_stall_held", 32'(slow), 32'd0);

      // Immediate refetch from the same line hits.
      r0 = req_count;
      applyStimulus(32'h1C00_0008, 1'b1);
      waitResponse("hit", cyc, slow);
      checkOutput("hit_latency", 32'(cyc), 32'd0);
      checkOutput("hit_rreq", 32'(mem_rreq), 32'd0);

      applyStimulus(32'h1C00_000C, 1'b1);
      waitResponse("cross", cyc, slow);
      checkOutput("cross_latency", 32'(cyc), 32'd0);
      checkOutput("hit_noreq", 32'(req_count - r0), 32'd0);

      // Conflict: same index, different tag, minimum grant wait.
      grant_delay = 1;
      r0 = req_count;
      applyStimulus(32'h1C00_0400, 1'b1);
      waitResponse("conflict", cyc, slow);
      checkOutput("conflict_reqs", 32'(req_count - r0), 32'd1);
      checkOutput("conflict_addr", last_addr, 32'h1C00_0400);
      checkOutput("conflict_latency", 32'(cyc), 32'd6);
      r0 = req_count;
      applyStimulus(32'h1C00_0004, 1'b1);
      waitResponse("evicted", cyc, slow);
      checkOutput("evicted_reqs", 32'(req_count - r0), 32'd1);
      checkOutput("evicted_latency", 32'(cyc), 32'd6);

      // Flush during refill: line still installs but no response is given.
      applyStimulus(32'h2000_0040, 1'b0);
      for (int i = 0; i < 40 && !(mem_busy && beats_sent >= 2); i++) @(negedge clk);
      checkOutput("flush_reached_beat2", 32'(mem_busy && beats_sent >= 2), 32'd1);
      flush_BR = 1'b1;
      @(negedge clk);
      flush_BR = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (o_valid != 2'b00) seen++;
         @(negedge clk);
      end
      checkOutput("flush_noresp", 32'(seen), 32'd0);
      checkOutput("flush_beats", 32'(beats_sent), 32'd4);
      checkOutput("flush_done_stall", 32'(stall_ICache), 32'd0);
      r0 = req_count;
      applyStimulus(32'h2000_0040, 1'b1);
      waitResponse("flush_hit", cyc, slow);
      checkOutput("flush_hit_latency", 32'(cyc), 32'd0);

      // A flush in the same cycle as a new request lets the request through.
      flush_BR = 1'b1;
      applyStimulus(32'h2000_0044, 1'b1);
      flush_BR = 1'b0;
      waitResponse("flush_new", cyc, slow);
      checkOutput("flush_hit_noreq", 32'(req_count - r0), 32'd0);

      // Reset mid-refill after the first beat.
      applyStimulus(32'h3000_0080, 1'b0);
      for (int i = 0; i < 40 && !(mem_busy && beats_sent >= 1); i++) @(negedge clk);
      checkOutput("rst_reached_beat1", 32'(mem_busy && beats_sent >= 1), 32'd1);
      rstn = 1'b0;
      #1;
      checkResetOutputs("midrst");
      for (int i = 0; i < 20 && mem_busy; i++) @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      r0 = req_count;
      applyStimulus(32'h3000_0080, 1'b1);
      waitResponse("post_rst", cyc, slow);
      checkOutput("post_rst_reqs", 32'(req_count - r0), 32'd1);
      checkOutput("post_rst_addr", last_addr, 32'h3000_0080);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
